start_token_srl_fifo: RTL and testbench

- Start-token FIFO that carries "start" events from a producer dataflow process to a downstream PE process (e.g. a PE_i4xi4 pack instance).
- Wraps a shift-register (SRL) storage array with full/empty handshake control and an occupancy counter.
- Sits between the upstream process's start_out/start_write handshake and the downstream process's start_full_n/ap_start inputs.
- Also usable as a generic small-depth data FIFO.

---
 rtl/start_token_srl_fifo_pkg.sv | 30 +++
 rtl/start_token_srl_storage.sv | 39 +++
 rtl/start_token_srl_fifo.sv | 83 ++++++++
 tb/tb_start_token_srl_fifo.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/start_token_srl_fifo_pkg.sv
// Shared helpers for the start-token SRL FIFO: width derivation and the
// encoding of the per-cycle queue operation.
package start_token_srl_fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

    // Occupancy runs 0..DEPTH, so it needs one bit more than the read address.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    localparam int DEFAULT_DEPTH       = 2;
    localparam int DEFAULT_ADDR_WIDTH  = clog2(DEFAULT_DEPTH);
    localparam int DEFAULT_COUNT_WIDTH = count_width(DEFAULT_ADDR_WIDTH);

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/start_token_srl_storage.sv
// Shift-register storage: every write pushes din into entry 0 and moves the
// rest down by one; the read side picks an entry by address.
module start_token_srl_storage #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    // Contents are deliberately left unreset so the array maps onto SRL cells.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign dout = mem_q[addr];

endmodule

// File: rtl/start_token_srl_fifo.sv
// Start-token FIFO: SRL storage plus registered occupancy, read address and
// full/empty flags. The oldest entry sits at address count-1.
module start_token_srl_fifo
    import start_token_srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_count
);

    localparam int              CW      = count_width(ADDR_WIDTH);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  wr, rd;
    fifo_op_e              op;

    // Handshake: a write is accepted on a cycle where if_write, if_write_ce and
    // if_full_n are all high; a read pops on a cycle where if_read, if_read_ce
    // and if_empty_n are all high. Flags come only from registers, so there is
    // no same-cycle bypass at full or empty.
    assign wr = if_write & if_write_ce & full_n_q;
    assign rd = if_read  & if_read_ce  & empty_n_q;

    always_comb begin
        op        = fifo_op_e'({wr, rd});
        count_d   = count_q;
        unique case (op)
            OP_WRITE: count_d = count_q + CW'(1);
            OP_READ:  count_d = count_q - CW'(1);
            default:  count_d = count_q;
        endcase
        addr_d    = (count_d != '0) ? ADDR_WIDTH'(count_d - CW'(1)) : '0;
        empty_n_d = (count_d != '0);
        full_n_d  = (count_d != DEPTH_C);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            addr_q    <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
        end else begin
            count_q   <= count_d;
            addr_q    <= addr_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
        end
    end

    start_token_srl_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk  (clk),
        .we   (wr),
        .addr (addr_q),
        .din  (if_din),
        .dout (if_dout)
    );

    assign if_full_n  = full_n_q;
    assign if_empty_n = empty_n_q;
    assign if_count   = count_q;

endmodule

// File: tb/tb_start_token_srl_fifo.sv
// Bench for start_token_srl_fifo: a DEPTH=2 and a DEPTH=4 instance share one
// stimulus stream and are each checked against a queue-based model.
module tb_start_token_srl_fifo;

    logic       clk;
    logic       rst_n;
    logic       wce, wr, rce, rd;
    logic [7:0] din;

    logic       d2_full_n, d2_empty_n;
    logic [3:0] d2_dout;
    logic [1:0] d2_count;
    logic       d4_full_n, d4_empty_n;
    logic [7:0] d4_dout;
    logic [2:0] d4_count;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q2[$];
    logic [7:0] exp_q4[$];

    start_token_srl_fifo #(.DATA_WIDTH(4), .ADDR_WIDTH(1), .DEPTH(2)) u_dut2 (
        .clk(clk), .reset_n(rst_n),
        .if_write_ce(wce), .if_write(wr), .if_din(din[3:0]), .if_full_n(d2_full_n),
        .if_read_ce(rce), .if_read(rd), .if_dout(d2_dout), .if_empty_n(d2_empty_n),
        .if_count(d2_count)
    );

    start_token_srl_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) u_dut4 (
        .clk(clk), .reset_n(rst_n),
        .if_write_ce(wce), .if_write(wr), .if_din(din), .if_full_n(d4_full_n),
        .if_read_ce(rce), .if_read(rd), .if_dout(d4_dout), .if_empty_n(d4_empty_n),
        .if_count(d4_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: a bounded queue per depth
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q2.delete();
            exp_q4.delete();
        end else begin
            bit w2, r2, w4, r4;
            w2 = wr && wce && (exp_q2.size() != 2);
            r2 = rd && rce && (exp_q2.size() != 0);
            w4 = wr && wce && (exp_q4.size() != 4);
            r4 = rd && rce && (exp_q4.size() != 0);
            if (r2) void'(exp_q2.pop_front());
            if (w2) exp_q2.push_back(din[3:0]);
            if (r4) void'(exp_q4.pop_front());
            if (w4) exp_q4.push_back(din);
        end
    end

    // monitor: compare flags, count and head of queue mid-cycle
    always @(negedge clk) begin
        check("d2_count",   32'(d2_count),   32'(exp_q2.size()));
        check("d2_empty_n", 32'(d2_empty_n), 32'(exp_q2.size() != 0));
        check("d2_full_n",  32'(d2_full_n),  32'(exp_q2.size() != 2));
        if (exp_q2.size() != 0) check("d2_dout", 32'(d2_dout), 32'(exp_q2[0]));
        check("d4_count",   32'(d4_count),   32'(exp_q4.size()));
        check("d4_empty_n", 32'(d4_empty_n), 32'(exp_q4.size() != 0));
        check("d4_full_n",  32'(d4_full_n),  32'(exp_q4.size() != 4));
        if (exp_q4.size() != 0) check("d4_dout", 32'(d4_dout), 32'(exp_q4[0]));
    end

    // driver: apply one cycle of inputs just after the rising edge
    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit wc, input bit rc);
        wr  = w;
        din = d;
        rd  = r;
        wce = wc;
        rce = rc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        wr = 1'b0; rd = 1'b0; wce = 1'b0; rce = 1'b0; din = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // idle after reset
        repeat (10) step(0, 8'h00, 0, 1, 1);

        // fill and drain order
        step(1, 8'h0A, 0, 1, 1);
        step(1, 8'h0B, 0, 1, 1);
        step(0, 8'h00, 0, 1, 1);
        step(0, 8'h00, 1, 1, 1);
        step(0, 8'h00, 1, 1, 1);
        step(0, 8'h00, 0, 1, 1);

        // overflow on the small instance, underflow on both
        step(1, 8'h0A, 0, 1, 1);
        step(1, 8'h0B, 0, 1, 1);
        step(1, 8'h0C, 0, 1, 1);
        step(0, 8'h00, 0, 1, 1);
        repeat (4) step(0, 8'h00, 1, 1, 1);
        step(0, 8'h00, 1, 1, 1);

        // simultaneous read/write, then wr&rd at full
        step(1, 8'h01, 0, 1, 1);
        step(1, 8'h02, 0, 1, 1);
        step(1, 8'h03, 1, 1, 1);
        step(0, 8'h00, 0, 1, 1);
        step(1, 8'h04, 0, 1, 1);
        step(1, 8'h05, 0, 1, 1);
        step(1, 8'h06, 1, 1, 1);
        step(0, 8'h00, 0, 1, 1);
        repeat (5) step(0, 8'h00, 1, 1, 1);

        // clock enables
        repeat (5) step(1, 8'h07, 0, 0, 1);
        step(1, 8'h08, 0, 1, 1);
        repeat (5) step(0, 8'h00, 1, 1, 0);
        repeat (2) step(0, 8'h00, 1, 1, 1);

        // asynchronous reset between edges
        step(1, 8'h11, 0, 1, 1);
        step(1, 8'h12, 0, 1, 1);
        step(1, 8'h13, 0, 1, 1);
        wr = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_d4_count",   32'(d4_count),   32'd0);
        check("arst_d4_empty_n", 32'(d4_empty_n), 32'd0);
        check("arst_d4_full_n",  32'(d4_full_n),  32'd1);
        check("arst_d2_count",   32'(d2_count),   32'd0);
        check("arst_d2_full_n",  32'(d2_full_n),  32'd1);
        rst_n = 1'b1;
        step(1, 8'h05, 0, 1, 1);
        step(0, 8'h00, 0, 1, 1);
        check("arst_readback", 32'(d4_dout), 32'h05);
        step(0, 8'h00, 1, 1, 1);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end
        repeat (6) step(0, 8'h00, 1, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
